tx_serializer_8b10b: RTL
========================

Name: tx_serializer_8b10b

Overview:
- 10-to-1 parallel-in/serial-out stage directly downstream of the 8b10b encoder in the TX path.
- Accepts one encoded 10-bit symbol every 10 bit clocks over a ready/valid handshake and shifts it out one bit per clock.
- On underrun (no valid symbol at the load slot), inserts a K28.5 comma whose polarity is chosen from the tracked running disparity, so the line stays DC-balanced.

Parameters:
- COMMA_NEG, 10'h17C, K28.5 for RD- (abcdei fghj = 001111 1010), symbol bit0 = a.
- COMMA_POS, 10'h283, K28.5 for RD+ (abcdei fghj = 110000 0101), symbol bit0 = a.
- UNDERRUN_CNT_W, 16, width of the underrun counter.

Ports:
- BitCLK, in, 1, serial bit clock; all state updates on its rising edge.
- Reset, in, 1, asynchronous active-high reset.
- TxParallel_10, in, 10, encoded symbol from the encoder; bit0 = a.
- TxValid, in, 1, TxParallel_10 holds a valid symbol.
- TxReady, out, 1, load slot; a transfer occurs when TxValid & TxReady are both high at a rising edge.
- TxSerial, out, 1, serial line bit.
- IdleInserted, out, 1, one-cycle pulse when a comma is loaded instead of data.
- RdPositive, out, 1, current running disparity (1 = RD+).
- UnderrunCnt, out, UNDERRUN_CNT_W, saturating count of comma insertions made after the first data transfer.

Behaviour:
- Reset values: bit counter cnt = 9, shift register = 0, TxSerial = 0, RdPositive = 0 (RD-), IdleInserted = 0, UnderrunCnt = 0, seen_data flag = 0.
- TxReady = (cnt == 9) & ~Reset, decoded combinationally from registered state. It is high in the first cycle after reset release.
- Counter: cnt counts 0..9 and wraps 9 -> 0 every cycle. Exactly one load slot per 10 clocks.
- Load at cnt == 9:
  - If TxValid = 1, the shift register loads TxParallel_10, seen_data is set, and IdleInserted = 0.
  - If TxValid = 0, the shift register loads COMMA_NEG when RD- or COMMA_POS when RD+, and IdleInserted pulses high for that cycle.
- Cycles with cnt != 9: shift register shifts right by 1 (zero fill). TxSerial is the registered shift register bit0.
- Latency: the bit a of the loaded symbol appears on TxSerial in the cycle immediately after the load edge; bit j appears 9 cycles later.
- TxValid outside the load slot is ignored, with no transfer. The upstream stage must hold data until TxReady.
- Running disparity: updated on every load from the popcount p of the loaded symbol.
  - p > 5: RD := +.
  - p < 5: RD := -.
  - p == 5: RD unchanged.
  - Comma loads update RD by the same rule: COMMA_NEG has p = 6 -> RD+, COMMA_POS has p = 4 -> RD-.
- UnderrunCnt increments on each comma load while seen_data = 1 and saturates at all-ones. Commas before the first data transfer are not counted.
- Reset asserted mid-symbol: all state returns to reset values immediately (asynchronous). The partial symbol is discarded and not resumed.

Optional Feature:
- Macro SER_MSB_FIRST_EN.
- Defined: transmission order is reversed. The shift register shifts left, TxSerial = shift register bit9, and symbol bit9 is sent first. Comma constants, disparity rule and counters are unchanged.
- Undefined: LSB-first, exactly as described above.

Test Plan:
- Reset release with TxValid = 0: TxReady = 1 in the first cycle; 0x17C is loaded and TxSerial sequence = 0,0,1,1,1,1,1,0,1,0; IdleInserted pulses once; RdPositive -> 1; UnderrunCnt stays 0.
- Continuing idle: the next slot loads 0x283, TxSerial = 1,1,0,0,0,0,0,1,0,1, RdPositive -> 0; commas alternate every 10 clocks.
- Data transfer of 0x2AA at a slot: TxSerial = 0,1,0,1,0,1,0,1,0,1, no IdleInserted, RdPositive unchanged (p = 5). The following idle slot emits the comma matching the held RD and UnderrunCnt = 1.
- Data 0x0FC (p = 6) from RD-, then TxValid low: RdPositive = 1 after the load, the next slot emits 0x283, UnderrunCnt increments.
- TxValid held high continuously with symbols A, B: exactly one transfer per 10 clocks, with TxReady high only at cnt = 9; back-to-back symbols with no gap bits.
- Reset pulsed at cnt = 4 mid-symbol: TxSerial = 0 and TxReady = 0 while in reset; after release TxReady = 1 immediately and the transmission restarts with a fresh comma at RD-.

Source files
------------

// File: rtl/tx_serializer_8b10b.sv
// tx_serializer_8b10b: 10:1 PISO stage behind the 8b10b encoder.
// One symbol is accepted every 10 bit clocks. When no symbol is offered at
// the load slot, a K28.5 comma of the polarity matching the running
// disparity is sent instead, so the line stays DC-balanced.
// Optional macro SER_MSB_FIRST_EN: send symbol bit9 first (shift left).
module tx_serializer_8b10b #(
    parameter logic [9:0] COMMA_NEG      = 10'h17C,
    parameter logic [9:0] COMMA_POS      = 10'h283,
    parameter int         UNDERRUN_CNT_W = 16
) (
    input  logic                      BitCLK,
    input  logic                      Reset,
    input  logic [9:0]                TxParallel_10,
    input  logic                      TxValid,
    output logic                      TxReady,
    output logic                      TxSerial,
    output logic                      IdleInserted,
    output logic                      RdPositive,
    output logic [UNDERRUN_CNT_W-1:0] UnderrunCnt
);

    localparam logic [3:0] LAST = 4'd9;
    localparam logic [UNDERRUN_CNT_W-1:0] UCNT_ONE = {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]                r_cnt;
    logic [9:0]                r_sr;
    logic                      r_rd;
    logic                      r_idle;
    logic                      r_seen;
    logic [UNDERRUN_CNT_W-1:0] r_ucnt;

    logic                      w_load;
    logic [9:0]                w_sym;
    logic [3:0]                w_pop;

    assign w_load = (r_cnt == LAST);

    // Pick the symbol for this slot and count its ones for the disparity update
    always_comb begin
        w_sym = TxValid ? TxParallel_10 : (r_rd ? COMMA_POS : COMMA_NEG);
        w_pop = '0;
        for (int i = 0; i < 10; i++) begin
            w_pop = w_pop + {3'b000, w_sym[i]};
        end
    end

    // Bit counter: 0..9, load slot at 9, wraps every cycle
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset)       r_cnt <= LAST;
        else if (w_load) r_cnt <= '0;
        else             r_cnt <= r_cnt + 4'd1;
    end

    // Shift register: parallel load at the slot, zero-fill shift otherwise
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset)       r_sr <= '0;
        else if (w_load) r_sr <= w_sym;
`ifdef SER_MSB_FIRST_EN
        else             r_sr <= {r_sr[8:0], 1'b0};
`else
        else             r_sr <= {1'b0, r_sr[9:1]};
`endif
    end

    // Running disparity follows the popcount of each loaded symbol; p == 5 holds it
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) begin
            r_rd <= 1'b0;
        end else if (w_load) begin
            if (w_pop > 4'd5)      r_rd <= 1'b1;
            else if (w_pop < 4'd5) r_rd <= 1'b0;
        end
    end

    // Idle pulse, first-data flag and saturating underrun counter
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) begin
            r_idle <= 1'b0;
            r_seen <= 1'b0;
            r_ucnt <= '0;
        end else if (w_load) begin
            r_idle <= ~TxValid;
            if (TxValid)
                r_seen <= 1'b1;
            else if (r_seen && (r_ucnt != '1))
                r_ucnt <= r_ucnt + UCNT_ONE;
        end else begin
            r_idle <= 1'b0;
        end
    end

    assign TxReady      = w_load & ~Reset;
`ifdef SER_MSB_FIRST_EN
    assign TxSerial     = r_sr[9];
`else
    assign TxSerial     = r_sr[0];
`endif
    assign IdleInserted = r_idle;
    assign RdPositive   = r_rd;
    assign UnderrunCnt  = r_ucnt;

endmodule
